// File: rtl/acc_cpu_pkg.sv
// rtl/acc_cpu_pkg.sv - shared opcode and FSM state definitions for the accumulator CPU
package acc_cpu_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_STA = 4'h2,
        OP_ADD = 4'h3,
        OP_SUB = 4'h4,
        OP_AND = 4'h5,
        OP_OR  = 4'h6,
        OP_XOR = 4'h7,
        OP_JMP = 4'h8,
        OP_JZ  = 4'h9,
        OP_JNZ = 4'hA,
        OP_JC  = 4'hB,
        OP_LDI = 4'hC,
        OP_NOT = 4'hD,
        OP_RSV = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_MEM    = 2'd2,
        ST_HALT   = 2'd3
    } state_e;

endpackage

// File: rtl/acc_cpu_alu.sv
// rtl/acc_cpu_alu.sv - combinational ALU: arithmetic, logic, load pass-through and NOT
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  opcode_e           op_i,
    input  logic [DATA_W-1:0] acc_i,
    input  logic [DATA_W-1:0] m_i,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    // The extra top bit of the difference is the unsigned borrow (acc < m).
    assign sum  = {1'b0, acc_i} + {1'b0, m_i};
    assign diff = {1'b0, acc_i} - {1'b0, m_i};

    always_comb begin
        result_o = acc_i;
        carry_o  = 1'b0;
        case (op_i)
            OP_ADD: begin
                result_o = sum[DATA_W-1:0];
                carry_o  = sum[DATA_W];
            end
            OP_SUB: begin
                result_o = diff[DATA_W-1:0];
                carry_o  = diff[DATA_W];
            end
            OP_AND:         result_o = acc_i & m_i;
            OP_OR:          result_o = acc_i | m_i;
            OP_XOR:         result_o = acc_i ^ m_i;
            OP_NOT:         result_o = ~acc_i;
            OP_LDA, OP_LDI: result_o = m_i;
            default:        result_o = acc_i;
        endcase
    end

endmodule

// File: rtl/acc_cpu.sv
// rtl/acc_cpu.sv - accumulator CPU top: control FSM, datapath registers, memory port
module acc_cpu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [ADDR_W-1:0] o_pc,
    output logic [DATA_W-1:0] o_acc,
    output logic              o_carry,
    output logic              o_zero,
    output logic              o_halted
);

    // Only the opcode and operand fields of an instruction are ever used, so only those are held.
    localparam int IR_W = OP_W + ADDR_W;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              carry_q, carry_d;
    logic [IR_W-1:0]   ir_q, ir_d;

    opcode_e           op;
    logic [ADDR_W-1:0] operand;
    logic              zero;
    logic              ack;
    logic [DATA_W-1:0] alu_m;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;

    assign op      = opcode_e'(ir_q[IR_W-1 -: OP_W]);
    assign operand = ir_q[ADDR_W-1:0];
    assign zero    = (acc_q == '0);

    // Request is gated by reset so an in-flight transaction is dropped immediately.
    assign o_mem_req   = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !i_rst;
    assign o_mem_we    = (state_q == ST_MEM) && (op == OP_STA);
    assign o_mem_addr  = (state_q == ST_MEM) ? operand : pc_q;
    assign o_mem_wdata = acc_q;
    assign ack         = o_mem_req && i_mem_ack;

    assign o_pc     = pc_q;
    assign o_acc    = acc_q;
    assign o_carry  = carry_q;
    assign o_zero   = zero;
    assign o_halted = (state_q == ST_HALT);

    // Memory ops take M from the bus; LDI takes the zero-extended operand.
    assign alu_m = (state_q == ST_MEM) ? i_mem_rdata
                                       : {{(DATA_W-ADDR_W){1'b0}}, operand};

    acc_cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op_i     (op),
        .acc_i    (acc_q),
        .m_i      (alu_m),
        .result_o (alu_result),
        .carry_o  (alu_carry)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        ir_d    = ir_q;
        case (state_q)
            ST_FETCH: begin
                if (ack) begin
                    ir_d    = {i_mem_rdata[DATA_W-1 -: OP_W], i_mem_rdata[ADDR_W-1:0]};
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_FETCH;
                case (op)
                    OP_LDA, OP_STA, OP_ADD, OP_SUB,
                    OP_AND, OP_OR, OP_XOR: state_d = ST_MEM;
                    OP_JMP:                pc_d    = operand;
                    OP_JZ:  if (zero)      pc_d    = operand;
                    OP_JNZ: if (!zero)     pc_d    = operand;
                    OP_JC:  if (carry_q)   pc_d    = operand;
                    OP_LDI, OP_NOT:        acc_d   = alu_result;
                    OP_HLT:                state_d = ST_HALT;
                    default:               state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (ack) begin
                    state_d = ST_FETCH;
                    if (op != OP_STA) begin
                        acc_d = alu_result;
                    end
                    if ((op == OP_ADD) || (op == OP_SUB)) begin
                        carry_d = alu_carry;
                    end
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            ir_q    <= ir_d;
        end
    end

endmodule

// File: tb/tb_acc_cpu.sv
// tb/tb_acc_cpu.sv - directed self-checking bench for acc_cpu with a wait-state memory model
module tb_acc_cpu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we, ack;
    logic [7:0]  addr;
    logic [15:0] wdata, rdata;
    logic [7:0]  pc;
    logic [15:0] acc;
    logic        carry, zero, halted;

    logic [15:0] mem [256];
    int          delay = 0;
    logic        force_ack = 1'b0;
    int          wait_cnt = 0;

    int total = 0;
    int passed = 0;

    logic        mon_en = 1'b0;
    int          cur_len = 0;
    int          len_err = 0;
    int          stab_err = 0;
    int          txn_cnt = 0;
    logic        pend = 1'b0;
    logic [7:0]  p_addr = '0;
    logic        p_we = 1'b0;
    logic [15:0] p_wdata = '0;

    always #5 clk = ~clk;

    acc_cpu #(.DATA_W(16), .ADDR_W(8)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .o_mem_req   (req),
        .o_mem_we    (we),
        .o_mem_addr  (addr),
        .o_mem_wdata (wdata),
        .i_mem_ack   (ack),
        .i_mem_rdata (rdata),
        .o_pc        (pc),
        .o_acc       (acc),
        .o_carry     (carry),
        .o_zero      (zero),
        .o_halted    (halted)
    );

    assign ack   = (req && (wait_cnt == delay)) || force_ack;
    assign rdata = mem[addr];

    always @(posedge clk) begin
        if (rst || !req || ack) wait_cnt <= 0;
        else                    wait_cnt <= wait_cnt + 1;
        if (req && ack && we) mem[addr] <= wdata;
    end

    // Tracks per-transaction request length and bus stability while waiting.
    always @(negedge clk) begin
        if (!mon_en || rst) begin
            cur_len <= 0;
            pend    <= 1'b0;
        end else if (req) begin
            if (pend && (addr !== p_addr || we !== p_we || wdata !== p_wdata))
                stab_err <= stab_err + 1;
            if (ack) begin
                if (cur_len + 1 != delay + 1) len_err <= len_err + 1;
                txn_cnt <= txn_cnt + 1;
                cur_len <= 0;
                pend    <= 1'b0;
            end else begin
                cur_len <= cur_len + 1;
                pend    <= 1'b1;
                p_addr  <= addr;
                p_we    <= we;
                p_wdata <= wdata;
            end
        end else begin
            cur_len <= 0;
            pend    <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        force_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic run_to_halt(output int n);
        n = 0;
        while (!halted && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_req_addr(input logic [7:0] a, output int n);
        n = 0;
        while (!(req && addr == a) && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic load_sum_prog();
        clear_mem();
        mem[8'h00] = 16'h1010;
        mem[8'h01] = 16'h3011;
        mem[8'h02] = 16'h2012;
        mem[8'h03] = 16'hF000;
        mem[8'h10] = 16'h0005;
        mem[8'h11] = 16'h0007;
    endtask

    initial begin
        int n;
        int bad;
        rst = 1'b1;
        clear_mem();
        @(negedge clk);
        @(negedge clk);
        check("rst_req",    req,    1'b0);
        check("rst_pc",     pc,     8'h00);
        check("rst_acc",    acc,    16'h0000);
        check("rst_carry",  carry,  1'b0);
        check("rst_halted", halted, 1'b0);

        // Sum program, zero-wait
        load_sum_prog();
        do_reset();
        check("first_req",  req,  1'b1);
        check("first_addr", addr, 8'h00);
        check("first_we",   we,   1'b0);
        run_to_halt(n);
        check("sum_cycles", n,          11);
        check("sum_halted", halted,     1'b1);
        check("sum_pc",     pc,         8'h04);
        check("sum_acc",    acc,        16'h000C);
        check("sum_mem12",  mem[8'h12], 16'h000C);
        check("sum_carry",  carry,      1'b0);
        check("sum_zero",   zero,       1'b0);

        // Halt is sticky while ack toggles
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            force_ack = ~force_ack;
            #1;
            if (req) bad++;
            @(negedge clk);
        end
        force_ack = 1'b0;
        check("halt_noreq",  bad,        0);
        check("halt_halted", halted,     1'b1);
        check("halt_pc",     pc,         8'h04);
        check("halt_acc",    acc,        16'h000C);
        check("halt_mem12",  mem[8'h12], 16'h000C);

        // Carry out and taken JC
        clear_mem();
        mem[8'h00] = 16'h1020;
        mem[8'h01] = 16'h3021;
        mem[8'h02] = 16'hB030;
        mem[8'h20] = 16'hFFFF;
        mem[8'h21] = 16'h0001;
        mem[8'h30] = 16'hF000;
        do_reset();
        wait_req_addr(8'h30, n);
        check("cy_cycles", n,     8);
        check("cy_addr",   addr,  8'h30);
        check("cy_we",     we,    1'b0);
        check("cy_acc",    acc,   16'h0000);
        check("cy_carry",  carry, 1'b1);
        check("cy_zero",   zero,  1'b1);

        // SUB borrow, NOT, XOR keep carry; JZ not taken, JNZ taken
        clear_mem();
        mem[8'h00] = 16'hC003;
        mem[8'h01] = 16'h4040;
        mem[8'h02] = 16'hD000;
        mem[8'h03] = 16'h7041;
        mem[8'h04] = 16'h9020;
        mem[8'h05] = 16'hA008;
        mem[8'h06] = 16'hC0FF;
        mem[8'h07] = 16'hF000;
        mem[8'h08] = 16'hF000;
        mem[8'h40] = 16'h0005;
        mem[8'h41] = 16'h00F0;
        do_reset();
        run_to_halt(n);
        check("lg_cycles", n,     16);
        check("lg_acc",    acc,   16'h00F1);
        check("lg_carry",  carry, 1'b1);
        check("lg_pc",     pc,    8'h09);

        // Sum program with three wait states per transaction
        load_sum_prog();
        delay  = 3;
        mon_en = 1'b1;
        do_reset();
        run_to_halt(n);
        mon_en = 1'b0;
        check("ws_cycles", n,          32);
        check("ws_len",    len_err,    0);
        check("ws_stable", stab_err,   0);
        check("ws_txns",   txn_cnt,    7);
        check("ws_pc",     pc,         8'h04);
        check("ws_acc",    acc,        16'h000C);
        check("ws_mem12",  mem[8'h12], 16'h000C);
        delay = 0;

        // PC wrap from FF to 00
        clear_mem();
        mem[8'h00] = 16'h80FF;
        mem[8'hFF] = 16'h0000;
        do_reset();
        wait_req_addr(8'hFF, n);
        check("wr_cycles", n,    2);
        check("wr_pc_ff",  pc,   8'hFF);
        @(negedge clk);
        n = 0;
        while (!req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wr_req",   req,  1'b1);
        check("wr_addr0", addr, 8'h00);
        check("wr_pc0",   pc,   8'h00);

        // Reset in the middle of a waiting load
        clear_mem();
        mem[8'h00] = 16'h1010;
        mem[8'h01] = 16'h3011;
        mem[8'h02] = 16'h1012;
        mem[8'h10] = 16'hFFFF;
        mem[8'h11] = 16'h0002;
        mem[8'h12] = 16'h1234;
        delay = 3;
        do_reset();
        wait_req_addr(8'h12, n);
        check("mr_pre_acc",   acc,   16'h0001);
        check("mr_pre_carry", carry, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        force_ack = 1'b1;
        #1;
        check("mr_req_gated", req, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        force_ack = 1'b0;
        #1;
        check("mr_req",    req,    1'b1);
        check("mr_addr",   addr,   8'h00);
        check("mr_acc",    acc,    16'h0000);
        check("mr_carry",  carry,  1'b0);
        check("mr_pc",     pc,     8'h00);
        check("mr_halted", halted, 1'b0);
        delay = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
